// File: rtl/accelerator_fnn_vector_transmitter_pkg.sv
// Shared constants and state type for the FNN vector transmitter.
package accelerator_fnn_vector_transmitter_pkg;

  localparam int FNN_DATA_SIZE    = 64;
  localparam int FNN_CONTROL_SIZE = 64;
  localparam int FNN_X            = 64;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } fnn_transmitter_state_t;

endpackage

// File: rtl/accelerator_fnn_vector_buffer.sv
// Vector holding buffer: one synchronous write port, one combinational read port.
module accelerator_fnn_vector_buffer #(
  parameter int DATA_SIZE = 64,
  parameter int LENGTH    = 64,
  parameter int ADDR_W    = $clog2(LENGTH)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [DATA_SIZE-1:0] rd_data
);

  // Contents deliberately survive reset.
  logic [DATA_SIZE-1:0] mem_q [LENGTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/accelerator_fnn_vector_transmitter.sv
// Returns a buffered vector one element per DATA_ENABLE request from the FNN controller.
//   state  | meaning
//   IDLE   | waiting for START; buffer loads accepted once BUSY has dropped
//   STREAM | one element per DATA_ENABLE until element len-1 is sent
//   DONE   | single cycle that raises READY
module accelerator_fnn_vector_transmitter
  import accelerator_fnn_vector_transmitter_pkg::*;
#(
  parameter int DATA_SIZE    = FNN_DATA_SIZE,
  parameter int CONTROL_SIZE = FNN_CONTROL_SIZE,
  parameter int LENGTH       = FNN_X
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  input  logic [CONTROL_SIZE-1:0]   LENGTH_IN,
  output logic                      READY,
  output logic                      BUSY,
  input  logic                      LOAD_ENABLE,
  input  logic [$clog2(LENGTH)-1:0] LOAD_ADDRESS,
  input  logic [DATA_SIZE-1:0]      LOAD_DATA,
  input  logic                      DATA_ENABLE,
  output logic [DATA_SIZE-1:0]      DATA_OUT,
  output logic                      DATA_OUT_ENABLE,
  output logic [CONTROL_SIZE-1:0]   INDEX_OUT
);

  localparam int AW = $clog2(LENGTH);
  localparam logic [CONTROL_SIZE-1:0] MAX_LEN = CONTROL_SIZE'(LENGTH);
  localparam logic [AW:0]             ADDR_LIMIT = (AW+1)'(LENGTH);

  fnn_transmitter_state_t  state_q, state_d;
  logic [CONTROL_SIZE-1:0] len_q, len_d;
  logic [CONTROL_SIZE-1:0] index_q, index_d;
  logic [CONTROL_SIZE-1:0] index_out_q, index_out_d;
  logic [DATA_SIZE-1:0]    data_out_q, data_out_d;
  logic                    busy_q, busy_d;
  logic                    ready_q, ready_d;
  logic                    data_out_enable_q, data_out_enable_d;

  logic [CONTROL_SIZE-1:0] len_clipped;
  logic                    buf_wr_en;
  logic [DATA_SIZE-1:0]    buf_rd_data;

  assign len_clipped = (LENGTH_IN > MAX_LEN) ? MAX_LEN : LENGTH_IN;
  // Writes are blocked for the whole BUSY window, including the READY cycle.
  assign buf_wr_en = LOAD_ENABLE && !busy_q && ({1'b0, LOAD_ADDRESS} < ADDR_LIMIT);

  accelerator_fnn_vector_buffer #(
    .DATA_SIZE(DATA_SIZE),
    .LENGTH   (LENGTH),
    .ADDR_W   (AW)
  ) u_buffer (
    .clk    (CLK),
    .wr_en  (buf_wr_en),
    .wr_addr(LOAD_ADDRESS),
    .wr_data(LOAD_DATA),
    .rd_addr(index_q[AW-1:0]),
    .rd_data(buf_rd_data)
  );

  always_comb begin
    state_d           = state_q;
    len_d             = len_q;
    index_d           = index_q;
    index_out_d       = index_out_q;
    data_out_d        = data_out_q;
    busy_d            = busy_q;
    ready_d           = 1'b0;
    data_out_enable_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        // busy_q is still high during the READY cycle, so START there is ignored.
        if (START && !busy_q) begin
          len_d   = len_clipped;
          index_d = '0;
          busy_d  = 1'b1;
          state_d = (len_clipped == '0) ? DONE : STREAM;
        end else begin
          busy_d = 1'b0;
        end
      end
      STREAM: begin
        if (DATA_ENABLE) begin
          data_out_enable_d = 1'b1;
          data_out_d        = buf_rd_data;
          index_out_d       = index_q;
          index_d           = index_q + CONTROL_SIZE'(1);
          if (index_q == len_q - CONTROL_SIZE'(1)) state_d = DONE;
        end
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q           <= IDLE;
      len_q             <= '0;
      index_q           <= '0;
      index_out_q       <= '0;
      data_out_q        <= '0;
      busy_q            <= 1'b0;
      ready_q           <= 1'b0;
      data_out_enable_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      len_q             <= len_d;
      index_q           <= index_d;
      index_out_q       <= index_out_d;
      data_out_q        <= data_out_d;
      busy_q            <= busy_d;
      ready_q           <= ready_d;
      data_out_enable_q <= data_out_enable_d;
    end
  end

  assign READY           = ready_q;
  assign BUSY            = busy_q;
  assign DATA_OUT        = data_out_q;
  assign DATA_OUT_ENABLE = data_out_enable_q;
  assign INDEX_OUT       = index_out_q;

endmodule

// File: tb/tb_accelerator_fnn_vector_transmitter.sv
// Scoreboard bench: transaction-level model predicts strobes, READY and BUSY per cycle.
module tb_accelerator_fnn_vector_transmitter;

  localparam int DS  = 64;
  localparam int CS  = 64;
  localparam int LEN = 64;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic [CS-1:0] LENGTH_IN;
  logic          READY;
  logic          BUSY;
  logic          LOAD_ENABLE;
  logic [5:0]    LOAD_ADDRESS;
  logic [DS-1:0] LOAD_DATA;
  logic          DATA_ENABLE;
  logic [DS-1:0] DATA_OUT;
  logic          DATA_OUT_ENABLE;
  logic [CS-1:0] INDEX_OUT;

  accelerator_fnn_vector_transmitter #(
    .DATA_SIZE(DS), .CONTROL_SIZE(CS), .LENGTH(LEN)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .START          (START),
    .LENGTH_IN      (LENGTH_IN),
    .READY          (READY),
    .BUSY           (BUSY),
    .LOAD_ENABLE    (LOAD_ENABLE),
    .LOAD_ADDRESS   (LOAD_ADDRESS),
    .LOAD_DATA      (LOAD_DATA),
    .DATA_ENABLE    (DATA_ENABLE),
    .DATA_OUT       (DATA_OUT),
    .DATA_OUT_ENABLE(DATA_OUT_ENABLE),
    .INDEX_OUT      (INDEX_OUT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [DS-1:0] data;
    int            idx;
  } exp_t;

  exp_t          exp_q[$];
  logic [DS-1:0] m_buf[LEN];
  bit            txn = 1'b0;
  int            m_n = 0;
  int            m_r = -1;
  int            m_len = 0;
  int            m_sent = 0;
  logic [DS-1:0] last_data = '0;
  logic [CS-1:0] last_idx = '0;
  int            errors = 0;
  int            checks = 0;

  // Transaction is busy from its START edge through its READY cycle.
  function automatic bit m_busy(int c);
    return txn && c >= m_n && (m_r < 0 || c <= m_r);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge(int e, bit st, logic [CS-1:0] li, bit le, int la,
                            logic [DS-1:0] ld, bit de);
    bit b;
    b = m_busy(e - 1);
    if (le && !b) m_buf[la] = ld;
    if (txn && e > m_n && m_sent < m_len && de) begin
      exp_q.push_back('{e, m_buf[m_sent], m_sent});
      m_sent++;
      if (m_sent == m_len) m_r = e + 1;
    end
    if (st && !b) begin
      txn    = 1'b1;
      m_n    = e;
      m_len  = (li > 64'd64) ? 64 : int'(li[6:0]);
      m_sent = 0;
      m_r    = (m_len == 0) ? e + 1 : -1;
    end
  endtask

  task automatic step(bit st, logic [CS-1:0] li, bit le, int la, logic [DS-1:0] ld, bit de);
    START        = st;
    LENGTH_IN    = li;
    LOAD_ENABLE  = le;
    LOAD_ADDRESS = la[5:0];
    LOAD_DATA    = ld;
    DATA_ENABLE  = de;
    @(posedge CLK);
    #1;
    model_edge(cyc, st, li, le, la, ld, de);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 0, '0, 1'b0);
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      exp_t e;
      check("busy", {63'd0, BUSY}, {63'd0, m_busy(cyc)});
      check("ready", {63'd0, READY}, {63'd0, (txn && cyc == m_r)});
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check("missed_strobe_idx", 64'hFFFF_FFFF_FFFF_FFFF, 64'(e.idx));
      end
      if (DATA_OUT_ENABLE) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got index %0d expected no strobe at cycle %0d",
                   INDEX_OUT, cyc);
        end else begin
          e = exp_q.pop_front();
          check("strobe_cycle", 64'(cyc), 64'(e.cyc));
          check("data_out", DATA_OUT, e.data);
          check("index_out", INDEX_OUT, 64'(e.idx));
          last_data = e.data;
          last_idx  = 64'(e.idx);
        end
      end else begin
        check("hold_data", DATA_OUT, last_data);
        check("hold_index", INDEX_OUT, last_idx);
      end
    end
  end

  task automatic do_reset_mid_cycle();
    START = 1'b0; LOAD_ENABLE = 1'b0; DATA_ENABLE = 1'b0;
    RST = 1'b1;
    #1;
    check("rst_ready", {63'd0, READY}, 64'd0);
    check("rst_busy", {63'd0, BUSY}, 64'd0);
    check("rst_strobe", {63'd0, DATA_OUT_ENABLE}, 64'd0);
    check("rst_data", DATA_OUT, 64'd0);
    check("rst_index", INDEX_OUT, 64'd0);
    txn = 1'b0;
    m_r = -1;
    exp_q.delete();
    last_data = '0;
    last_idx  = '0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    logic [CS-1:0] li;
    int            sel;
    RST = 1'b1; START = 1'b0; LENGTH_IN = '0; LOAD_ENABLE = 1'b0;
    LOAD_ADDRESS = '0; LOAD_DATA = '0; DATA_ENABLE = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("init_busy", {63'd0, BUSY}, 64'd0);
    check("init_index", INDEX_OUT, 64'd0);
    RST = 1'b0;

    for (int a = 0; a < LEN; a++) step(1'b0, '0, 1'b1, a, {$urandom, $urandom}, 1'b0);
    for (int a = 0; a < 4; a++) step(1'b0, '0, 1'b1, a, 64'(10 * (a + 1)), 1'b0);
    idle(2);

    // Sparse requests.
    step(1'b1, 64'd4, 1'b0, 0, '0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b0, 0, '0, (i % 3) == 2);
    idle(4);

    // Back-to-back requests with extras after the last element.
    step(1'b1, 64'd4, 1'b0, 0, '0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b0, 0, '0, 1'b1);
    idle(4);

    // Zero length.
    step(1'b1, 64'd0, 1'b0, 0, '0, 1'b1);
    idle(4);

    // Length clipped to buffer depth.
    step(1'b1, 64'd100, 1'b0, 0, '0, 1'b0);
    for (int i = 0; i < 70; i++) step(1'b0, '0, 1'b0, 0, '0, 1'b1);
    idle(3);
    check("clip_last_index", INDEX_OUT, 64'd63);

    // START and LOAD while busy are ignored.
    step(1'b1, 64'd4, 1'b0, 0, '0, 1'b0);
    step(1'b0, '0, 1'b0, 0, '0, 1'b1);
    step(1'b1, 64'd2, 1'b1, 1, 64'd99, 1'b0);
    step(1'b0, '0, 1'b1, 1, 64'd99, 1'b1);
    step(1'b0, '0, 1'b0, 0, '0, 1'b1);
    step(1'b0, '0, 1'b0, 0, '0, 1'b1);
    step(1'b0, '0, 1'b0, 0, '0, 1'b1);
    idle(4);
    check("busy_load_ignored", m_buf[1], 64'd20);

    // Reset mid-stream, then a fresh short transmission.
    step(1'b1, 64'd4, 1'b0, 0, '0, 1'b0);
    step(1'b0, '0, 1'b0, 0, '0, 1'b1);
    step(1'b0, '0, 1'b0, 0, '0, 1'b1);
    @(negedge CLK);
    #1;
    do_reset_mid_cycle();
    idle(3);
    step(1'b1, 64'd2, 1'b0, 0, '0, 1'b0);
    step(1'b0, '0, 1'b0, 0, '0, 1'b1);
    step(1'b0, '0, 1'b0, 0, '0, 1'b1);
    idle(4);

    // Randomized transactions with interfering START/LOAD traffic.
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 4; i++)
        step(1'b0, '0, $urandom_range(0, 1) == 1, $urandom_range(0, LEN - 1),
             {$urandom, $urandom}, $urandom_range(0, 1) == 1);
      sel = $urandom_range(0, 9);
      if (sel < 7)       li = 64'($urandom_range(0, 70));
      else if (sel == 7) li = 64'd100;
      else if (sel == 8) li = {$urandom | 32'h1, $urandom};
      else               li = 64'd0;
      step(1'b1, li, $urandom_range(0, 1) == 1, $urandom_range(0, LEN - 1),
           {$urandom, $urandom}, $urandom_range(0, 1) == 1);
      for (int k = 0; k < 400 && m_busy(cyc); k++)
        step($urandom_range(0, 7) == 0, 64'($urandom_range(0, 70)),
             $urandom_range(0, 7) == 0, $urandom_range(0, LEN - 1),
             {$urandom, $urandom}, $urandom_range(0, 2) != 0);
      check("txn_completed", {63'd0, m_busy(cyc)}, 64'd0);
      idle(2);
    end

    idle(3);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
